// File: rtl/mcu_port_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mcu_port_pkg
// Brief    : Shared constants, scheduler state type and index helper for the
//            MCU port arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package mcu_port_pkg;

  localparam int         MAX_PORTS        = 4;
  localparam logic [7:0] PORT_TYPE_SERIAL = 8'd0;

  typedef enum logic [0:0] {
    SCHED_IDLE  = 1'b0,
    SCHED_SERVE = 1'b1
  } sched_state_t;

  function automatic logic port_in_range(input logic [7:0] idx, input int num_ports);
    return idx < 8'(num_ports);
  endfunction

endpackage
`default_nettype wire

// File: rtl/mcu_port_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : mcu_port_arbiter_if
// Brief    : MCU-side command/data channel of the port arbiter.
// Revision : 1.0 - initial release
// ============================================================================
interface mcu_port_arbiter_if;

  logic [7:0]                          sel_index;
  logic                                sel_load;
  logic [7:0]                          out_available;
  logic                                out_strobe;
  logic [7:0]                          out_data;
  logic [7:0]                          in_available;
  logic                                in_strobe;
  logic [7:0]                          in_data;
  logic [31:0]                         status;
  logic                                sel_valid;
  logic                                irq;
  logic                                irq_ack;
  logic [mcu_port_pkg::MAX_PORTS-1:0]  pending;
  logic [1:0]                          next_port;

  modport master (
    output sel_index, sel_load, out_strobe, in_strobe, in_data, irq_ack,
    input  out_available, out_data, in_available, status, sel_valid, irq,
           pending, next_port
  );

  modport slave (
    input  sel_index, sel_load, out_strobe, in_strobe, in_data, irq_ack,
    output out_available, out_data, in_available, status, sel_valid, irq,
           pending, next_port
  );

endinterface
`default_nettype wire

// File: rtl/port_rr_sched.sv
`default_nettype none
// ============================================================================
// Module   : port_rr_sched
// Brief    : Picks the port the MCU should read next from the pending flags.
//            MCU_PORT_ARB_RR_EN selects round-robin, otherwise fixed priority.
// Revision : 1.0 - initial release
// ============================================================================
module port_rr_sched
  import mcu_port_pkg::*;
#(
  parameter int NUM_PORTS = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [MAX_PORTS-1:0] pending,
  input  logic                 sel_load,
  input  logic [7:0]           sel_index,
  output logic [1:0]           next_port
);

  sched_state_t r_state;
  sched_state_t w_state_next;
  logic [1:0]   r_held;
  logic [1:0]   w_search;
  logic [1:0]   w_next_port;
  logic         w_found;
  logic         w_any;

  assign w_any = |pending;

`ifdef MCU_PORT_ARB_RR_EN
  localparam logic [1:0] c_last_init = 2'(NUM_PORTS - 1);

  logic [1:0] r_last_served;
  logic [2:0] w_idx;

  // Only a selection that actually services a pending port moves the pointer.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_last_served <= c_last_init;
    end else if (sel_load && port_in_range(sel_index, NUM_PORTS) &&
                 pending[sel_index[1:0]]) begin
      r_last_served <= sel_index[1:0];
    end
  end

  always_comb begin
    w_search = r_last_served;
    w_found  = 1'b0;
    w_idx    = 3'd0;
    for (int k = 1; k <= NUM_PORTS; k++) begin
      w_idx = {1'b0, r_last_served} + 3'(k);
      if (w_idx >= 3'(NUM_PORTS)) begin
        w_idx = w_idx - 3'(NUM_PORTS);
      end
      if (!w_found && pending[w_idx[1:0]]) begin
        w_search = w_idx[1:0];
        w_found  = 1'b1;
      end
    end
  end
`else
  logic w_unused_sel;
  assign w_unused_sel = &{1'b0, sel_load, sel_index};

  always_comb begin
    w_search = 2'd0;
    w_found  = 1'b0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      if (!w_found && pending[k]) begin
        w_search = 2'(k);
        w_found  = 1'b1;
      end
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= SCHED_IDLE;
      r_held  <= 2'd0;
    end else begin
      r_state <= w_state_next;
      r_held  <= w_next_port;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      SCHED_IDLE:  if (w_any)  w_state_next = SCHED_SERVE;
      SCHED_SERVE: if (!w_any) w_state_next = SCHED_IDLE;
      default:     w_state_next = SCHED_IDLE;
    endcase
  end

  // The recommendation freezes while idle so the MCU sees a stable value.
  always_comb begin
    w_next_port = r_held;
    if (r_state == SCHED_SERVE && w_found) begin
      w_next_port = w_search;
    end
  end

  assign next_port = w_next_port;

endmodule
`default_nettype wire

// File: rtl/mcu_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mcu_port_arbiter
// Brief    : Multiplexes up to four device ports onto one MCU port channel,
//            with pending/irq tracking and a next-port recommendation.
//            MCU_PORT_ARB_RR_EN enables the round-robin recommendation.
// Revision : 1.0 - initial release
// ============================================================================
module mcu_port_arbiter
  import mcu_port_pkg::*;
#(
  parameter int NUM_PORTS = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  mcu_port_arbiter_if.slave       mcu,
  input  logic [8*NUM_PORTS-1:0]  dev_out_available,
  input  logic [8*NUM_PORTS-1:0]  dev_out_data,
  input  logic [8*NUM_PORTS-1:0]  dev_in_available,
  input  logic [32*NUM_PORTS-1:0] dev_status,
  output logic [NUM_PORTS-1:0]    dev_out_strobe,
  output logic [NUM_PORTS-1:0]    dev_in_strobe,
  output logic [7:0]              dev_in_data
);

  logic [7:0]           w_oav  [MAX_PORTS];
  logic [7:0]           w_odat [MAX_PORTS];
  logic [7:0]           w_iav  [MAX_PORTS];
  logic [31:0]          w_stat [MAX_PORTS];
  logic [MAX_PORTS-1:0] w_pend_now;

  // Absent ports read as empty so all selection logic can use full-size arrays.
  for (genvar p = 0; p < MAX_PORTS; p++) begin : g_port
    if (p < NUM_PORTS) begin : g_live
      assign w_oav[p]  = dev_out_available[8*p +: 8];
      assign w_odat[p] = dev_out_data[8*p +: 8];
      assign w_iav[p]  = dev_in_available[8*p +: 8];
      assign w_stat[p] = dev_status[32*p +: 32];
    end else begin : g_absent
      assign w_oav[p]  = 8'd0;
      assign w_odat[p] = 8'd0;
      assign w_iav[p]  = 8'd0;
      assign w_stat[p] = 32'd0;
    end
  end

  always_comb begin
    w_pend_now = '0;
    for (int p = 0; p < MAX_PORTS; p++) begin
      w_pend_now[p] = |w_oav[p];
    end
  end

  logic [1:0]  r_sel;
  logic        r_sel_valid;
  logic [1:0]  w_sel_next;
  logic        w_sel_valid_next;
  logic [7:0]  r_out_av;
  logic [7:0]  r_out_data;
  logic [7:0]  r_in_av;
  logic [31:0] r_status;

  assign w_sel_next       = mcu.sel_load ? mcu.sel_index[1:0] : r_sel;
  assign w_sel_valid_next = mcu.sel_load ? port_in_range(mcu.sel_index, NUM_PORTS)
                                         : r_sel_valid;

  // Mux registers follow the incoming selection so a new sel is visible next cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sel       <= 2'd0;
      r_sel_valid <= 1'b1;
      r_out_av    <= 8'd0;
      r_out_data  <= 8'd0;
      r_in_av     <= 8'd0;
      r_status    <= 32'd0;
    end else begin
      r_sel       <= w_sel_next;
      r_sel_valid <= w_sel_valid_next;
      if (w_sel_valid_next) begin
        r_out_av   <= w_oav[w_sel_next];
        r_out_data <= w_odat[w_sel_next];
        r_in_av    <= w_iav[w_sel_next];
        r_status   <= w_stat[w_sel_next];
      end else begin
        r_out_av   <= 8'd0;
        r_out_data <= 8'd0;
        r_in_av    <= 8'd0;
        r_status   <= 32'd0;
      end
    end
  end

  logic                 w_out_ok;
  logic                 w_in_ok;
  logic [NUM_PORTS-1:0] w_out_vec;
  logic [NUM_PORTS-1:0] w_in_vec;
  logic [NUM_PORTS-1:0] r_out_strobe;
  logic [NUM_PORTS-1:0] r_in_strobe;
  logic [7:0]           r_in_data;

  // Strobes target the currently registered sel, never one loaded this cycle.
  assign w_out_ok = mcu.out_strobe && r_sel_valid && (w_oav[r_sel] != 8'd0);
  assign w_in_ok  = mcu.in_strobe  && r_sel_valid && (w_iav[r_sel] != 8'd0);

  always_comb begin
    w_out_vec = '0;
    w_in_vec  = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (r_sel == 2'(p)) begin
        w_out_vec[p] = w_out_ok;
        w_in_vec[p]  = w_in_ok;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_out_strobe <= '0;
      r_in_strobe  <= '0;
      r_in_data    <= 8'd0;
    end else begin
      r_out_strobe <= w_out_vec;
      r_in_strobe  <= w_in_vec;
      if (w_in_ok) begin
        r_in_data <= mcu.in_data;
      end
    end
  end

  logic [MAX_PORTS-1:0] r_pending;
  logic [MAX_PORTS-1:0] r_pending_d;
  logic                 r_irq;

  // A fresh rise outranks an acknowledge arriving in the same cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pending   <= '0;
      r_pending_d <= '0;
      r_irq       <= 1'b0;
    end else begin
      r_pending   <= w_pend_now;
      r_pending_d <= r_pending;
      if (|(r_pending & ~r_pending_d)) begin
        r_irq <= 1'b1;
      end else if (mcu.irq_ack) begin
        r_irq <= 1'b0;
      end
    end
  end

  logic [1:0] w_next_port;

  port_rr_sched #(
    .NUM_PORTS (NUM_PORTS)
  ) u_sched (
    .clk       (clk),
    .reset     (reset),
    .pending   (r_pending),
    .sel_load  (mcu.sel_load),
    .sel_index (mcu.sel_index),
    .next_port (w_next_port)
  );

  assign mcu.out_available = r_out_av;
  assign mcu.out_data      = r_out_data;
  assign mcu.in_available  = r_in_av;
  assign mcu.status        = r_status;
  assign mcu.sel_valid     = r_sel_valid;
  assign mcu.irq           = r_irq;
  assign mcu.pending       = r_pending;
  assign mcu.next_port     = w_next_port;
  assign dev_out_strobe    = r_out_strobe;
  assign dev_in_strobe     = r_in_strobe;
  assign dev_in_data       = r_in_data;

endmodule
`default_nettype wire

// File: doc/mcu_port_arbiter.md
MCU_PORT_ARBITER -- requirements
Module: mcu_port_arbiter

Interface
REQ-001 Parameter: NUM_PORTS, default 4, number of device ports sharing the MCU port channel (legal 1..4).
REQ-002 clk  input  1  system clock; all state updates on its rising edge.
REQ-003 reset  input  1  reset, synchronous, active-high.
REQ-004 sel_index  input  8  port index byte received from the MCU port command.
REQ-005 sel_load  input  1  one-cycle strobe that latches sel_index.
REQ-006 out_available  output  8  bytes pending towards the MCU on the selected port.
REQ-007 out_strobe  input  1  pop one byte from the selected port.
REQ-008 out_data  output  8  head byte of the selected port.
REQ-009 in_available  output  8  free input-buffer bytes on the selected port.
REQ-010 in_strobe / in_data  input  1 / 8  push one byte into the selected port.
REQ-011 status  output  32  status word of the selected port.
REQ-012 sel_valid  output  1  latched index < NUM_PORTS.
REQ-013 irq  output  1  level interrupt request, data newly pending.
REQ-014 irq_ack  input  1  one-cycle strobe clearing irq.
REQ-015 pending  output  4  per-port flag, out_available != 0; bits >= NUM_PORTS read 0.
REQ-016 next_port  output  2  port the scheduler recommends the MCU read next.
REQ-017 dev_out_available [8*N], dev_out_data [8*N], dev_in_available [8*N], dev_status [32*N]  inputs; dev_out_strobe [N], dev_in_strobe [N], dev_in_data [8]  outputs.

Function
REQ-018 sel_load registers sel_index into sel; sel_valid = (sel_index < NUM_PORTS), updated in the same cycle.
REQ-019 Outputs out_available, out_data, in_available and status are registered muxes of port sel, with 1-cycle latency from a device change or from sel_load.
REQ-020 If sel_valid = 0: out_available, in_available and status = 0, out_data = 8'h00; strobes are dropped.
REQ-021 out_strobe drives dev_out_strobe[sel] for exactly one cycle, registered with 1-cycle latency; in_strobe drives dev_in_strobe[sel] and dev_in_data = in_data with the same latency.
REQ-022 out_strobe while dev_out_available[sel] = 0 is suppressed (no underflow); in_strobe while dev_in_available[sel] = 0 is suppressed (no overflow).
REQ-023 sel_load in the same cycle as a strobe: the strobe is applied to the old sel, and the new sel takes effect the next cycle.
REQ-024 pending is registered each cycle; a rising edge of any pending bit sets irq.
REQ-025 irq_ack clears irq; a new rising edge in the same cycle as irq_ack wins, so irq stays 1.
REQ-026 Scheduler states: IDLE (no pending) and SERVE (at least one pending); next_port holds its value in IDLE.
REQ-027 In SERVE, next_port = first pending port searching upward from last_served+1, with wrap-around modulo NUM_PORTS.
REQ-028 last_served updates to sel when sel_load selects a valid port whose pending bit is set.
REQ-029 SERVE goes to IDLE the cycle after pending == 0.

Reset
REQ-030 During reset: sel=0, sel_valid=1, last_served=NUM_PORTS-1, next_port=0, irq=0, pending=0, all strobes=0, mux outputs=0, state IDLE.
REQ-031 Reset asserted mid-transfer drops any registered strobe; no device sees a strobe in the cycle after reset deasserts.

Configuration
REQ-032 Macro MCU_PORT_ARB_RR_EN defined: the round-robin scheduler of REQ-027/028 is compiled in.
REQ-033 MCU_PORT_ARB_RR_EN undefined: next_port = lowest-index pending port (fixed priority); last_served logic is absent; all other behaviour is identical.

Structure
REQ-034 Shared package mcu_port_pkg holds MAX_PORTS=4, port type code PORT_TYPE_SERIAL=8'd0, and the scheduler state enum.
REQ-035 Sub-module port_rr_sched holds the pending-to-next_port search and the last_served register; the top level instantiates it.

Verification
REQ-036 Set dev_out_available[2]=0→3, then ack: irq rises 1 cycle after pending[2] rises; irq_ack → irq=0 next cycle.
REQ-037 sel_load with index 1, dev_out_data[1]=8'hA5: out_data=8'hA5 one cycle later; out_strobe → dev_out_strobe[1] pulses once, 1 cycle after.
REQ-038 sel_load with index 7 (NUM_PORTS=4): sel_valid=0, out_available=0, status=0; in_strobe produces no dev_in_strobe.
REQ-039 Ports 0 and 3 pending, last_served=3: next_port=0; after sel_load(0), next_port=3 (RR_EN); without the macro, next_port stays 0.
REQ-040 out_strobe with dev_out_available[sel]=0 → no dev_out_strobe; in_strobe with dev_in_available[sel]=0 → no dev_in_strobe.
REQ-041 Assert reset the cycle after out_strobe: dev_out_strobe stays 0, irq=0, sel=0.
